bnn_dot_initiator: RTL and testbench
====================================

BNN_DOT_INITIATOR -- requirements
Module: bnn_dot_initiator

Interface
REQ-001 SHALL have parameter CFU_FUNC_ID_W, default 5, CFU function-ID width.
REQ-002 SHALL have parameter CFU_REQ_DATA_W, default 32, request operand width.
REQ-003 SHALL have parameter CFU_RESP_DATA_W, default 32, response data width.
REQ-004 SHALL have parameter LEN_W, default 8, word-count width.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-008 cmd_len  in  LEN_W  number of 32b words in the dot product.
REQ-009 in_valid / in_ready  in / out  1 / 1  operand-word handshake.
REQ-010 in_act, in_wgt  in  CFU_REQ_DATA_W each  activation and weight word.
REQ-011 req_valid / req_ready  out / in  1 / 1  CFU request handshake.
REQ-012 req_func_id  out  CFU_FUNC_ID_W  always 0 (BNN dot product).
REQ-013 req_data0, req_data1  out  CFU_REQ_DATA_W  activation, weight.
REQ-014 resp_valid / resp_ready  in / out  1 / 1  CFU response handshake.
REQ-015 resp_data  in  CFU_RESP_DATA_W  per-word popcount of XNOR.
REQ-016 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-017 out_sum  out  32  accumulated result.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, REQ, WAIT, DONE.
REQ-019 IDLE: cmd_ready=1. On cmd_valid, latch cmd_len into count and len_q and clear acc; go FETCH, or DONE if cmd_len==0.
REQ-020 FETCH: in_ready=1. On in_valid, register in_act/in_wgt into req_data0/req_data1; go REQ.
REQ-021 REQ: req_valid=1, req_data0/1 held stable until req_ready sampled high; then go WAIT.
REQ-022 WAIT: resp_ready=1. On resp_valid, acc += resp_data (32b, wraps mod 2^32) and count -= 1; go DONE if the new count==0, else FETCH.
REQ-023 DONE: out_valid=1, out_sum held stable until out_ready; then go IDLE.
REQ-024 Exactly one CFU request SHALL be outstanding at a time. A resp_valid outside WAIT SHALL be ignored.
REQ-025 All handshake outputs SHALL be registered-state decodes only, with no combinational path from any input.
REQ-026 Minimum latency, with all peers always ready: cmd accepted at cycle 0, then 3 cycles per word, then out_valid at cycle 3*len+1.
REQ-027 With cmd_len==0, out_valid=1 and out_sum=0 (or the signed value per REQ-031) in the cycle after command acceptance.

Reset
REQ-028 While rst_n=0: state=IDLE; acc, count, len_q, req_data0, req_data1 = 0; outputs cmd_ready=1, in_ready=0, req_valid=0, resp_ready=0, out_valid=0, out_sum=0.
REQ-029 Reset asserted mid-operation SHALL abandon the command with no result produced. The first command after rst_n rises SHALL behave as from power-up.

Configuration
REQ-030 Macro BNN_SIGNED_RESULT_EN controls the result format.
REQ-031 Defined: out_sum = 2*acc - 32*len_q, as 32b two's complement (true ±1 dot product).
REQ-032 Undefined: out_sum = acc (biased popcount sum).

Verification
REQ-033 Bench SHALL cover: len=1, act=wgt=0xFFFFFFFF, responder returns 32 -> out_sum=32 (signed: 32), out_valid at cycle 4.
REQ-034 Bench SHALL cover: len=2, act=0x00000000, wgt=0xFFFFFFFF, responses 0,0 -> out_sum=0 (signed: 0xFFFFFFC0 = -64).
REQ-035 Bench SHALL cover: len=0 -> out_valid the next cycle, out_sum=0, no req_valid ever raised.
REQ-036 Bench SHALL cover: len=1, req_ready low 3 cycles -> req_valid held, req_data0/1 unchanged, exactly one request accepted.
REQ-037 Bench SHALL cover: out_ready low 5 cycles in DONE -> out_sum stable, cmd_ready=0 until out_ready.
REQ-038 Bench SHALL cover: rst_n pulsed low in WAIT of len=3 -> all outputs at reset values; a new len=1 command then yields the correct result.

Source files
------------

// File: rtl/bnn_dot_initiator.sv
// Streams activation/weight word pairs to a CFU BNN dot-product unit, one request in flight,
// and accumulates the returned popcounts. Define BNN_SIGNED_RESULT_EN to report the signed +/-1 dot product.
module bnn_dot_initiator #(
    parameter int CFU_FUNC_ID_W   = 5,
    parameter int CFU_REQ_DATA_W  = 32,
    parameter int CFU_RESP_DATA_W = 32,
    parameter int LEN_W           = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [LEN_W-1:0]           cmd_len,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CFU_REQ_DATA_W-1:0]  in_act,
    input  logic [CFU_REQ_DATA_W-1:0]  in_wgt,

    output logic                       req_valid,
    input  logic                       req_ready,
    output logic [CFU_FUNC_ID_W-1:0]   req_func_id,
    output logic [CFU_REQ_DATA_W-1:0]  req_data0,
    output logic [CFU_REQ_DATA_W-1:0]  req_data1,

    input  logic                       resp_valid,
    output logic                       resp_ready,
    input  logic [CFU_RESP_DATA_W-1:0] resp_data,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_sum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO_C = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE_C  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                      state_r;
    state_t                      state_nxt_s;
    logic [31:0]                 acc_r;
    logic [31:0]                 acc_nxt_s;
    logic [LEN_W-1:0]            count_r;
    logic [LEN_W-1:0]            count_nxt_s;
    logic [CFU_REQ_DATA_W-1:0]   data0_nxt_s;
    logic [CFU_REQ_DATA_W-1:0]   data1_nxt_s;
`ifdef BNN_SIGNED_RESULT_EN
    logic [LEN_W-1:0]            len_r;
    logic [LEN_W-1:0]            len_nxt_s;
    logic [31:0]                 len_ext_s;
`endif

    // Next-state and datapath update for the command/word/request/response sequence
    always_comb begin
        state_nxt_s = state_r;
        acc_nxt_s   = acc_r;
        count_nxt_s = count_r;
        data0_nxt_s = req_data0;
        data1_nxt_s = req_data1;
`ifdef BNN_SIGNED_RESULT_EN
        len_nxt_s   = len_r;
`endif
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    count_nxt_s = cmd_len;
                    acc_nxt_s   = 32'd0;
`ifdef BNN_SIGNED_RESULT_EN
                    len_nxt_s   = cmd_len;
`endif
                    state_nxt_s = (cmd_len == LEN_ZERO_C) ? DONE : FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    data0_nxt_s = in_act;
                    data1_nxt_s = in_wgt;
                    state_nxt_s = REQ;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            REQ: begin
                if (req_ready) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT: begin
                // Last word is the one whose response brings the count to zero
                if (resp_valid) begin
                    acc_nxt_s   = acc_r + 32'(resp_data);
                    count_nxt_s = count_r - LEN_ONE_C;
                    state_nxt_s = (count_r == LEN_ONE_C) ? DONE : FETCH;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, accumulator, word counter and request operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            acc_r     <= 32'd0;
            count_r   <= LEN_ZERO_C;
            req_data0 <= {CFU_REQ_DATA_W{1'b0}};
            req_data1 <= {CFU_REQ_DATA_W{1'b0}};
`ifdef BNN_SIGNED_RESULT_EN
            len_r     <= LEN_ZERO_C;
`endif
        end else begin
            state_r   <= state_nxt_s;
            acc_r     <= acc_nxt_s;
            count_r   <= count_nxt_s;
            req_data0 <= data0_nxt_s;
            req_data1 <= data1_nxt_s;
`ifdef BNN_SIGNED_RESULT_EN
            len_r     <= len_nxt_s;
`endif
        end
    end

    // Handshake outputs decode the registered state only
    assign cmd_ready   = (state_r == IDLE);
    assign in_ready    = (state_r == FETCH);
    assign req_valid   = (state_r == REQ);
    assign resp_ready  = (state_r == WAIT);
    assign out_valid   = (state_r == DONE);
    assign req_func_id = {CFU_FUNC_ID_W{1'b0}};

`ifdef BNN_SIGNED_RESULT_EN
    // Each word contributes (matches - mismatches) = 2*popcount - 32
    assign len_ext_s = 32'(len_r);
    assign out_sum   = {acc_r[30:0], 1'b0} - {len_ext_s[26:0], 5'b00000};
`else
    assign out_sum   = acc_r;
`endif

endmodule

// File: tb/tb_bnn_dot_initiator.sv
// Bench for bnn_dot_initiator: directed vector table, hand-written stall/reset sequences,
// and randomized transactions scored against a popcount-sum reference model.
`timescale 1ns/1ps
module tb_bnn_dot_initiator;

    localparam int LEN_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_valid, cmd_ready;
    logic [LEN_W-1:0]  cmd_len;
    logic              in_valid, in_ready;
    logic [31:0]       in_act, in_wgt;
    logic              req_valid, req_ready;
    logic [4:0]        req_func_id;
    logic [31:0]       req_data0, req_data1;
    logic              resp_valid, resp_ready;
    logic [31:0]       resp_data;
    logic              out_valid, out_ready;
    logic [31:0]       out_sum;

    bnn_dot_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
        .req_valid(req_valid), .req_ready(req_ready), .req_func_id(req_func_id),
        .req_data0(req_data0), .req_data1(req_data1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] act_a [0:63];
    logic [31:0] wgt_a [0:63];
    logic [31:0] rsp_a [0:63];
    int idx, nreq, pend, dly, stall_pct, reqv_seen;

    typedef struct {
        int          len;
        logic [31:0] act;
        logic [31:0] wgt;
        logic [31:0] exp_sum;
        int          exp_lat;
    } vec_t;
    vec_t vecs [0:4];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] xnor_pop(input logic [31:0] a, input logic [31:0] b);
        int c = 0;
        for (int i = 0; i < 32; i++) if (a[i] == b[i]) c++;
        return 32'(c);
    endfunction

    // Result from the specification: sum of responses mod 2^32, optionally 2*sum - 32*len
    function automatic logic [31:0] model_sum(input int len);
        longint s = 0;
        for (int k = 0; k < len; k++) s += longint'(rsp_a[k]);
`ifdef BNN_SIGNED_RESULT_EN
        s = 2 * s - 32 * longint'(len);
`endif
        return s[31:0];
    endfunction

    function automatic bit roll();
        return $urandom_range(0, 99) >= stall_pct;
    endfunction

    task automatic drive_peers(input int len);
        in_valid  = (idx < len) && roll();
        in_act    = (idx < len) ? act_a[idx] : $urandom();
        in_wgt    = (idx < len) ? wgt_a[idx] : $urandom();
        req_ready = roll();
        if (pend != 0) begin
            if (dly > 0) begin
                dly--;
                resp_valid = 1'b0;
            end else begin
                resp_valid = 1'b1;
                resp_data  = rsp_a[nreq-1];
            end
        end else begin
            resp_valid = (stall_pct > 0) && ($urandom_range(0, 3) == 0);
            resp_data  = $urandom();
        end
        out_ready = roll();
    endtask

    task automatic run_txn(input int len, output logic [31:0] got, output int lat);
        int cyc = 0, cmd_cyc = 0, first_out = -1;
        bit done = 1'b0, c_f, i_f, q_f, r_f, o_f;
        logic [31:0] held = 32'd0;
        idx = 0; nreq = 0; pend = 0; dly = 0; reqv_seen = 0;
        got = 32'hDEAD_BEEF; lat = -1;
        cmd_len = LEN_W'(len);
        cmd_valid = 1'b1;
        drive_peers(len);
        while (!done && cyc < 3000) begin
            if (req_valid) begin
                reqv_seen++;
                check32("one_outstanding", 32'(pend), 32'd0);
                if (nreq < len) begin
                    check32("req_data0", req_data0, act_a[nreq]);
                    check32("req_data1", req_data1, wgt_a[nreq]);
                end
            end
            if (out_valid) begin
                if (first_out < 0) begin
                    first_out = cyc;
                    held = out_sum;
                end else begin
                    check32("out_sum_stable", out_sum, held);
                end
            end
            c_f = cmd_valid && cmd_ready;
            i_f = in_valid && in_ready;
            q_f = req_valid && req_ready;
            r_f = resp_valid && resp_ready;
            o_f = out_valid && out_ready;
            tick();
            cyc++;
            if (c_f) begin cmd_valid = 1'b0; cmd_cyc = cyc - 1; end
            if (i_f) idx++;
            if (q_f) begin
                nreq++;
                pend = 1;
                dly = (stall_pct == 0) ? 0 : int'($urandom_range(0, 3));
            end
            if (r_f) pend = 0;
            if (o_f) begin done = 1'b1; got = held; lat = first_out - cmd_cyc; end
            drive_peers(len);
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL txn_timeout: len=%0d no result after %0d cycles, required a result", len, cyc);
        end
        cmd_valid = 1'b0; in_valid = 1'b0; req_ready = 1'b0; resp_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a, w, exp;
        int lat, len;

        vecs[0] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd32, 4};
`ifdef BNN_SIGNED_RESULT_EN
        vecs[1] = '{2, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFC0, 7};
`else
        vecs[1] = '{2, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 7};
`endif
        vecs[2] = '{0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1};
        vecs[3] = '{3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'd96, 10};
`ifdef BNN_SIGNED_RESULT_EN
        vecs[4] = '{4, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd0, 13};
`else
        vecs[4] = '{4, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'd64, 13};
`endif

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_len = '0; in_valid = 1'b0; in_act = '0; in_wgt = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0; out_ready = 1'b0; stall_pct = 0;
        repeat (2) tick();
        check32("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check32("rst_in_ready", 32'(in_ready), 32'd0);
        check32("rst_req_valid", 32'(req_valid), 32'd0);
        check32("rst_resp_ready", 32'(resp_ready), 32'd0);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_out_sum", out_sum, 32'd0);
        check32("rst_req_data0", req_data0, 32'd0);
        check32("rst_func_id", 32'(req_func_id), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors with all peers always ready
        for (int v = 0; v < 5; v++) begin
            stall_pct = 0;
            for (int k = 0; k < vecs[v].len; k++) begin
                act_a[k] = vecs[v].act;
                wgt_a[k] = vecs[v].wgt;
                rsp_a[k] = xnor_pop(vecs[v].act, vecs[v].wgt);
            end
            run_txn(vecs[v].len, got, lat);
            check32($sformatf("vec%0d_sum", v), got, vecs[v].exp_sum);
            check32($sformatf("vec%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
            check32($sformatf("vec%0d_nreq", v), 32'(nreq), 32'(vecs[v].len));
            if (vecs[v].len == 0) check32("len0_no_req_valid", 32'(reqv_seen), 32'd0);
        end

        // req_ready held low for three cycles while a request is presented
        a = 32'h1234_5678; w = 32'h1234_0000;
        cmd_len = 8'd1; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
        in_act = a; in_wgt = w; in_valid = 1'b1; req_ready = 1'b0; tick();
        in_valid = 1'b0; in_act = $urandom(); in_wgt = $urandom();
        for (int k = 0; k < 3; k++) begin
            check32("stall_req_valid", 32'(req_valid), 32'd1);
            check32("stall_req_data0", req_data0, a);
            check32("stall_req_data1", req_data1, w);
            tick();
        end
        req_ready = 1'b1;
        check32("stall_req_valid_final", 32'(req_valid), 32'd1);
        tick();
        check32("stall_single_request", 32'(req_valid), 32'd0);
        check32("stall_resp_ready", 32'(resp_ready), 32'd1);
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = xnor_pop(a, w); tick();
        resp_valid = 1'b0;
`ifdef BNN_SIGNED_RESULT_EN
        exp = 32'd16;
`else
        exp = 32'd24;
`endif
        check32("stall_out_valid", 32'(out_valid), 32'd1);
        check32("stall_out_sum", out_sum, exp);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check32("stall_back_idle", 32'(cmd_ready), 32'd1);

        // out_ready held low for five cycles; stray responses and a pending command must be ignored
        cmd_len = 8'd1; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
        in_act = 32'hFFFF_0000; in_wgt = 32'hFFFF_0000; in_valid = 1'b1; tick();
        in_valid = 1'b0; req_ready = 1'b1; tick();
        req_ready = 1'b0; resp_valid = 1'b1; resp_data = 32'd32; tick();
        resp_valid = 1'b0;
        cmd_valid = 1'b1; cmd_len = 8'd2; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check32("hold_out_valid", 32'(out_valid), 32'd1);
            check32("hold_out_sum", out_sum, 32'd32);
            check32("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            resp_valid = 1'b1; resp_data = 32'd1000;
            tick();
            resp_valid = 1'b0;
        end
        out_ready = 1'b1; tick();
        cmd_valid = 1'b0; out_ready = 1'b0;
        check32("hold_release_cmd_ready", 32'(cmd_ready), 32'd1);
        check32("hold_release_out_valid", 32'(out_valid), 32'd0);

        // Reset pulsed while waiting on the first response of a three-word command
        cmd_len = 8'd3; cmd_valid = 1'b1; tick(); cmd_valid = 1'b0;
        in_act = 32'hCAFE_F00D; in_wgt = 32'h1357_9BDF; in_valid = 1'b1; tick();
        in_valid = 1'b0; req_ready = 1'b1; tick(); req_ready = 1'b0;
        check32("mid_in_wait", 32'(resp_ready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check32("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check32("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check32("mid_rst_req_valid", 32'(req_valid), 32'd0);
        check32("mid_rst_resp_ready", 32'(resp_ready), 32'd0);
        check32("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check32("mid_rst_out_sum", out_sum, 32'd0);
        check32("mid_rst_req_data0", req_data0, 32'd0);
        check32("mid_rst_req_data1", req_data1, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check32("post_rst_out_valid", 32'(out_valid), 32'd0);
        stall_pct = 0;
        act_a[0] = $urandom(); wgt_a[0] = $urandom(); rsp_a[0] = xnor_pop(act_a[0], wgt_a[0]);
        run_txn(1, got, lat);
        check32("post_rst_sum", got, model_sum(1));
        check32("post_rst_latency", 32'(lat), 32'd4);

        // Randomized transactions with random back-pressure and full-width responses
        for (int t = 0; t < 30; t++) begin
            len = $urandom_range(0, 6);
            stall_pct = $urandom_range(0, 60);
            for (int k = 0; k < len; k++) begin
                act_a[k] = $urandom();
                wgt_a[k] = $urandom();
                rsp_a[k] = (t % 2 == 1) ? $urandom() : xnor_pop(act_a[k], wgt_a[k]);
            end
            run_txn(len, got, lat);
            check32($sformatf("rand%0d_sum", t), got, model_sum(len));
            check32($sformatf("rand%0d_nreq", t), 32'(nreq), 32'(len));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
